// File: rtl/hs_cdc_rx_mc.sv
// hs_cdc_rx_mc: multi-channel req/ack receiver for clock-domain crossing.
// Each channel synchronises its foreign req and captures its payload into a
// hold register. A round-robin arbiter then moves held words one at a time into
// a single valid/ready output register.
// Ports:
//   clk_receiver, rst          - receiver clock, async active-high reset
//   req_async[CH]              - per-channel foreign request (level or toggle)
//   data_async[CH*DATA_W]      - per-channel payload, stable while req pending
//   ack[CH]                    - per-channel acknowledge (registered)
//   out_valid/out_ready        - output handshake
//   out_data, out_ch           - delivered payload and its source channel
module hs_cdc_rx_mc #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CH          = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          PHASE4      = 1'b1,
    localparam int unsigned CH_W       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk_receiver,
    input  logic                 rst,
    input  logic [CH-1:0]        req_async,
    input  logic [CH*DATA_W-1:0] data_async,
    output logic [CH-1:0]        ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [CH_W-1:0]      out_ch
);

    typedef enum logic [1:0] {StIdle, StPend, StAck} state_e;

    logic [CH-1:0]     sync_q [SYNC_STAGES];
    logic [CH-1:0]     sync_d [SYNC_STAGES];
    state_e            state_q [CH];
    state_e            state_d [CH];
    logic [DATA_W-1:0] hold_q [CH];
    logic [DATA_W-1:0] hold_d [CH];
    logic [CH-1:0]     req_last_q, req_last_d;
    logic [CH-1:0]     ack_q, ack_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    logic [CH-1:0]     req_s;
    logic [CH-1:0]     req_evt;
    logic [CH-1:0]     grant;
    logic [CH_W-1:0]   grant_idx;
    logic              any_grant;
    logic              can_load;

    assign req_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chains.
    always_comb begin
        sync_d[0] = req_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Request detection: level in 4-phase, edge against req_last in 2-phase.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            if (PHASE4) begin
                req_evt[k] = (state_q[k] == StIdle) && req_s[k];
            end else begin
                req_evt[k] = (state_q[k] == StIdle) && (req_s[k] != req_last_q[k]);
            end
        end
    end

    // Round-robin arbiter. The output register is free when empty or draining.
    always_comb begin
        logic [CH_W-1:0] idx;
        can_load  = !out_valid_q || out_ready;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        if (can_load) begin
            for (int i = 0; i < CH; i++) begin
                idx = CH_W'((int'(rr_q) + i) % CH);
                if (!any_grant && (state_q[idx] == StPend)) begin
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                    any_grant  = 1'b1;
                end
            end
        end
        rr_d = any_grant ? CH_W'((int'(grant_idx) + 1) % CH) : rr_q;
    end

    // State register.
    always_ff @(posedge clk_receiver or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int k = 0; k < CH; k++) begin
                state_q[k] <= StIdle;
                hold_q[k]  <= '0;
            end
            req_last_q  <= '0;
            ack_q       <= '0;
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            req_last_q  <= req_last_d;
            ack_q       <= ack_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    // Next-state logic. Once pending, a channel ignores req until granted.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            state_d[k] = state_q[k];
            unique case (state_q[k])
                StIdle: if (req_evt[k]) state_d[k] = StPend;
                StPend: begin
                    if (grant[k]) begin
                        if (PHASE4) state_d[k] = StAck;
                        else        state_d[k] = StIdle;
                    end
                end
                StAck:  if (!req_s[k]) state_d[k] = StIdle;
                default: state_d[k] = StIdle;
            endcase
        end
    end

    // Outputs and datapath. Ack changes on the same edge the word is loaded.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            hold_d[k]     = req_evt[k] ? data_async[k*DATA_W +: DATA_W] : hold_q[k];
            req_last_d[k] = req_evt[k] ? req_s[k] : req_last_q[k];
            ack_d[k]      = ack_q[k];
            if (PHASE4) begin
                if (grant[k]) begin
                    ack_d[k] = 1'b1;
                end else if ((state_q[k] == StAck) && !req_s[k]) begin
                    ack_d[k] = 1'b0;
                end
            end else if (grant[k]) begin
                ack_d[k] = ~ack_q[k];
            end
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (any_grant) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q[grant_idx];
            out_ch_d    = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_hs_cdc_rx_mc.sv
// Self-checking bench for hs_cdc_rx_mc: a 4-phase instance (dut4) and a
// 2-phase instance (dut2), both CH=2, DATA_W=8, SYNC_STAGES=2.
`timescale 1ns/100ps
module tb_hs_cdc_rx_mc;
    localparam int LAT = 4;  // SYNC_STAGES + 2

    typedef struct packed {
        logic       ch;
        logic [7:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic fclk = 1'b0;
    logic rst = 1'b1;
    always #15 clk = ~clk;
    always #22.5 fclk = ~fclk;

    logic [1:0]  req4 = '0;
    logic [15:0] data4 = '0;
    logic [1:0]  ack4;
    logic        ov4;
    logic        ordy4 = 1'b1;
    logic [7:0]  od4;
    logic [0:0]  och4;

    logic [1:0]  req2 = '0;
    logic [15:0] data2 = '0;
    logic [1:0]  ack2;
    logic        ov2;
    logic        ordy2 = 1'b1;
    logic [7:0]  od2;
    logic [0:0]  och2;

    hs_cdc_rx_mc #(.DATA_W(8), .CH(2), .SYNC_STAGES(2), .PHASE4(1'b1)) dut4 (
        .clk_receiver(clk), .rst(rst), .req_async(req4), .data_async(data4),
        .ack(ack4), .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_ch(och4)
    );

    hs_cdc_rx_mc #(.DATA_W(8), .CH(2), .SYNC_STAGES(2), .PHASE4(1'b0)) dut2 (
        .clk_receiver(clk), .rst(rst), .req_async(req2), .data_async(data2),
        .ack(ack2), .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_ch(och2)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] q4_0[$];
    logic [7:0] q4_1[$];
    logic [7:0] q2[$];
    logic [7:0] mon_e4;
    logic [7:0] mon_e2;
    bit rand_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_extra(input string name, input logic [7:0] act);
        total++;
        bad++;
        $display("FAIL %s: got unexpected word 0x%0h want none", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov4(input string name, output int n);
        n = 0;
        while (ov4 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, ov4, 1);
    endtask

    task automatic wait_ov2(input string name, output int n);
        n = 0;
        while (ov2 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, ov2, 1);
    endtask

    task automatic wait_ack4(input int ch, input logic v, input string name);
        int n = 0;
        while (ack4[ch] !== v && n < 20) begin
            tick();
            n++;
        end
        chk(name, ack4[ch], v);
    endtask

    // Foreign-domain 4-phase sender for one channel of dut4.
    task automatic fchan(input int ch, input int n);
        int cnt;
        logic [7:0] d;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge fclk);
            d = 8'($urandom);
            data4[ch*8 +: 8] = d;
            if (ch == 0) q4_0.push_back(d);
            else q4_1.push_back(d);
            req4[ch] = 1'b1;
            cnt = 0;
            while (ack4[ch] !== 1'b1 && cnt < 100) begin
                @(posedge fclk);
                cnt++;
            end
            chk("rand_ack_rise", ack4[ch], 1);
            req4[ch] = 1'b0;
            cnt = 0;
            while (ack4[ch] !== 1'b0 && cnt < 100) begin
                @(posedge fclk);
                cnt++;
            end
            chk("rand_ack_fall", ack4[ch], 0);
        end
    endtask

    // Scoreboard monitors: a word is consumed on the next edge iff valid&ready now.
    always @(negedge clk) begin
        if (!rst && ov4 && ordy4) begin
            if (och4 == 1'b0) begin
                if (q4_0.size() == 0) sb_extra("sb4_ch0_extra", od4);
                else begin
                    mon_e4 = q4_0.pop_front();
                    chk("sb4_ch0_data", od4, mon_e4);
                end
            end else begin
                if (q4_1.size() == 0) sb_extra("sb4_ch1_extra", od4);
                else begin
                    mon_e4 = q4_1.pop_front();
                    chk("sb4_ch1_data", od4, mon_e4);
                end
            end
        end
        if (!rst && ov2 && ordy2) begin
            chk("sb2_ch", och2, 1);
            if (q2.size() == 0) sb_extra("sb2_extra", od2);
            else begin
                mon_e2 = q2.pop_front();
                chk("sb2_data", od2, mon_e2);
            end
        end
    end

    initial begin
        vec_t vecs[4];
        int n;
        vecs[0] = '{ch: 1'b0, data: 8'hA5};
        vecs[1] = '{ch: 1'b1, data: 8'h3C};
        vecs[2] = '{ch: 1'b0, data: 8'h0F};
        vecs[3] = '{ch: 1'b1, data: 8'hF0};

        // Reset state
        repeat (2) tick();
        chk("rst_ack4", ack4, 0);
        chk("rst_ov4", ov4, 0);
        chk("rst_od4", od4, 0);
        chk("rst_och4", och4, 0);
        chk("rst_ack2", ack2, 0);
        chk("rst_ov2", ov2, 0);
        rst = 1'b0;
        tick();

        // Single-channel deliveries, no contention, out_ready=1
        for (int i = 0; i < 4; i++) begin
            data4[vecs[i].ch*8 +: 8] = vecs[i].data;
            if (vecs[i].ch == 1'b0) q4_0.push_back(vecs[i].data);
            else q4_1.push_back(vecs[i].data);
            req4[vecs[i].ch] = 1'b1;
            wait_ov4("vec_valid", n);
            chk("vec_latency_ok", (n <= LAT), 1);
            chk("vec_och", och4, vecs[i].ch);
            chk("vec_od", od4, vecs[i].data);
            chk("vec_ack_hi", ack4[vecs[i].ch], 1);
            chk("vec_ack_other", ack4[~vecs[i].ch], 0);
            req4[vecs[i].ch] = 1'b0;
            wait_ack4(vecs[i].ch, 1'b0, "vec_ack_release");
            tick();
        end

        // Simultaneous requests: ch0 first, ch1 next cycle; repeated to show
        // the pointer returns to ch0.
        for (int r = 0; r < 2; r++) begin
            data4 = {8'h22, 8'h11};
            q4_0.push_back(8'h11);
            q4_1.push_back(8'h22);
            req4 = 2'b11;
            wait_ov4("both_valid", n);
            chk("both_first_ch", och4, 0);
            chk("both_first_data", od4, 8'h11);
            chk("both_first_ack", ack4, 2'b01);
            tick();
            chk("both_second_valid", ov4, 1);
            chk("both_second_ch", och4, 1);
            chk("both_second_data", od4, 8'h22);
            chk("both_second_ack", ack4, 2'b11);
            req4 = 2'b00;
            wait_ack4(0, 1'b0, "both_ack0_release");
            wait_ack4(1, 1'b0, "both_ack1_release");
            tick();
        end

        // Backpressure: out_data holds and ch1 is not acked until ch0 drains
        ordy4 = 1'b0;
        data4 = {8'h44, 8'h33};
        q4_0.push_back(8'h33);
        q4_1.push_back(8'h44);
        req4 = 2'b11;
        wait_ov4("bp_valid", n);
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold_data", od4, 8'h33);
            chk("bp_hold_ch", och4, 0);
            chk("bp_hold_valid", ov4, 1);
            chk("bp_ack1_low", ack4[1], 0);
            tick();
        end
        ordy4 = 1'b1;
        tick();
        chk("bp_next_valid", ov4, 1);
        chk("bp_next_data", od4, 8'h44);
        chk("bp_next_ch", och4, 1);
        chk("bp_next_ack1", ack4[1], 1);
        req4 = 2'b00;
        wait_ack4(0, 1'b0, "bp_ack0_release");
        wait_ack4(1, 1'b0, "bp_ack1_release");
        tick();

        // Reset while ch0 is in ACK; held req yields one fresh delivery
        data4[7:0] = 8'h5A;
        q4_0.push_back(8'h5A);
        req4[0] = 1'b1;
        wait_ov4("rst_pre_valid", n);
        chk("rst_pre_ack", ack4[0], 1);
        rst = 1'b1;
        #1;
        chk("rst_async_ack", ack4, 0);
        chk("rst_async_valid", ov4, 0);
        chk("rst_async_data", od4, 0);
        repeat (2) tick();
        rst = 1'b0;
        wait_ov4("rst_fresh_valid", n);
        chk("rst_fresh_data", od4, 8'h5A);
        chk("rst_fresh_ack", ack4[0], 1);
        repeat (4) tick();
        req4[0] = 1'b0;
        wait_ack4(0, 1'b0, "rst_fresh_release");
        repeat (4) tick();
        chk("rst_no_dup_valid", ov4, 0);
        chk("rst_q0_empty", q4_0.size(), 0);

        // Random traffic from a 45 ns foreign clock into the 30 ns receiver
        fork
            begin
                fork
                    fchan(0, 12);
                    fchan(1, 12);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    ordy4 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ordy4 = 1'b1;
        repeat (10) tick();
        chk("rand_q0_empty", q4_0.size(), 0);
        chk("rand_q1_empty", q4_1.size(), 0);
        chk("rand_idle_valid", ov4, 0);

        // 2-phase: three toggles on ch1
        for (int i = 1; i <= 3; i++) begin
            data2[15:8] = 8'(i);
            q2.push_back(8'(i));
            req2[1] = ~req2[1];
            wait_ov2("tog_valid", n);
            chk("tog_latency_ok", (n <= LAT), 1);
            chk("tog_data", od2, i);
            chk("tog_ack", ack2[1], i % 2);
            chk("tog_ack0", ack2[0], 0);
            repeat (3) tick();
        end
        chk("tog_ack_final", ack2[1], 1);
        chk("tog_q_empty", q2.size(), 0);
        chk("tog_idle_valid", ov2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
